cfu_mac_engine: RTL



---
 rtl/cfu_mac_engine.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cfu_mac_engine.sv
// CFU front-end owning A/B int8 operand buffers and a C accumulator buffer,
// with a pipelined LANES-wide dot-product engine driven over cmd/rsp.
module cfu_mac_engine #(
    parameter int ADDR_BITS   = 12,
    parameter int C_ADDR_BITS = 8,
    parameter int LANES       = 4,
    parameter int ACC_BITS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, MEMRD, EXEC, DRAIN, RSP} state_t;

    localparam logic [2:0] OP_CLEAR      = 3'd0;
    localparam logic [2:0] OP_WRITE      = 3'd1;
    localparam logic [2:0] OP_COMPUTE    = 3'd2;
    localparam logic [2:0] OP_READ_C     = 3'd3;
    localparam logic [2:0] OP_SET_OFFSET = 3'd4;
    localparam logic [2:0] OP_DEBUG      = 3'd7;

    state_t state_reg, state_next;

    logic [2:0]             op_reg;
    logic                   f0_reg;
    logic [ADDR_BITS-1:0]   a_ptr_reg, b_ptr_reg;
    logic [15:0]            k_reg;
    logic [C_ADDR_BITS-1:0] cidx_reg;
    logic signed [8:0]      offset_reg;
    logic [ACC_BITS-1:0]    acc_reg, prod_reg, acc_sum;
    logic                   rd_valid_reg, prod_valid_reg, drain_reg;
    logic [31:0]            payload_reg;

    logic [31:0]            a_mem [2**ADDR_BITS];
    logic [31:0]            b_mem [2**ADDR_BITS];
    logic [ACC_BITS-1:0]    c_mem [2**C_ADDR_BITS];
    logic [31:0]            a_rdata, b_rdata;
    logic [ACC_BITS-1:0]    c_rdata, c_wdata;
    logic [ADDR_BITS-1:0]   a_addr, b_addr;
    logic [C_ADDR_BITS-1:0] c_addr;
    logic                   a_we, b_we, c_we;

    logic [2:0]  cmd_op;
    logic        cmd_f0, accept;
    logic [15:0] cmd_k;
    logic signed [31:0] lane_prod [LANES];
    logic signed [31:0] dot_sum;
    logic        unused_bits;

    assign cmd_op    = cmd_payload_function_id[2:0];
    assign cmd_f0    = cmd_payload_function_id[3];
    assign cmd_k     = cmd_payload_inputs_1[15:0];
    assign accept    = cmd_valid && (state_reg == IDLE);
    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign rsp_valid = (state_reg == RSP);
    assign rsp_payload_outputs_0 = payload_reg;
    assign unused_bits = ^{cmd_payload_function_id, cmd_payload_inputs_0,
                           cmd_payload_inputs_1, a_rdata, b_rdata, dot_sum};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (cmd_valid) begin
                if (cmd_op == OP_COMPUTE)
                    state_next = cmd_f0 ? MEMRD : ((cmd_k == 16'd0) ? RSP : EXEC);
                else if (cmd_op == OP_READ_C || cmd_op == OP_DEBUG)
                    state_next = MEMRD;
                else
                    state_next = RSP;
            end
            MEMRD: state_next = (op_reg == OP_COMPUTE && k_reg != 16'd0) ? EXEC : RSP;
            EXEC:  if (k_reg == 16'd1) state_next = DRAIN;
            DRAIN: if (drain_reg) state_next = RSP;
            RSP:   if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command path owns the buffer ports only while idle; the engine owns them otherwise.
    assign a_addr  = (state_reg == IDLE) ? cmd_payload_inputs_0[ADDR_BITS-1:0] : a_ptr_reg;
    assign b_addr  = (state_reg == IDLE) ? cmd_payload_inputs_0[ADDR_BITS-1:0] : b_ptr_reg;
    assign a_we    = accept && (cmd_op == OP_WRITE) && !cmd_f0;
    assign b_we    = accept && (cmd_op == OP_WRITE) && cmd_f0;
    assign acc_sum = acc_reg + (prod_valid_reg ? prod_reg : '0);

    // The final accumulate and the C write-back share the edge that enters RSP.
    always_comb begin
        c_addr  = cidx_reg;
        c_we    = 1'b0;
        c_wdata = acc_sum;
        if (state_reg == IDLE) begin
            c_addr = (cmd_op == OP_READ_C) ? cmd_payload_inputs_0[C_ADDR_BITS-1:0]
                                           : cmd_payload_inputs_1[16 +: C_ADDR_BITS];
            if (accept && cmd_op == OP_COMPUTE && !cmd_f0 && cmd_k == 16'd0) begin
                c_we    = 1'b1;
                c_wdata = '0;
            end
        end else if (state_reg == MEMRD && op_reg == OP_COMPUTE && k_reg == 16'd0) begin
            c_we    = 1'b1;
            c_wdata = c_rdata;
        end else if (state_reg == DRAIN && drain_reg) begin
            c_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (a_we) a_mem[a_addr] <= cmd_payload_inputs_1;
        else      a_rdata <= a_mem[a_addr];
        if (b_we) b_mem[b_addr] <= cmd_payload_inputs_1;
        else      b_rdata <= b_mem[b_addr];
        if (c_we) c_mem[c_addr] <= c_wdata;
        else      c_rdata <= c_mem[c_addr];
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [9:0] a_off;
            assign a_off = 10'($signed(a_rdata[8*gi +: 8])) + 10'(offset_reg);
            assign lane_prod[gi] = 32'(a_off) * 32'($signed(b_rdata[8*gi +: 8]));
        end
    endgenerate

    always_comb begin
        dot_sum = '0;
        for (int l = 0; l < LANES; l++) dot_sum = dot_sum + lane_prod[l];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg         <= '0;
            f0_reg         <= 1'b0;
            a_ptr_reg      <= '0;
            b_ptr_reg      <= '0;
            k_reg          <= '0;
            cidx_reg       <= '0;
            offset_reg     <= '0;
            acc_reg        <= '0;
            prod_reg       <= '0;
            rd_valid_reg   <= 1'b0;
            prod_valid_reg <= 1'b0;
            drain_reg      <= 1'b0;
            payload_reg    <= '0;
        end else begin
            rd_valid_reg   <= (state_reg == EXEC);
            prod_valid_reg <= rd_valid_reg;
            prod_reg       <= dot_sum[ACC_BITS-1:0];
            if (c_we) payload_reg <= 32'(c_wdata);
            case (state_reg)
                IDLE: if (accept) begin
                    op_reg    <= cmd_op;
                    f0_reg    <= cmd_f0;
                    a_ptr_reg <= cmd_payload_inputs_0[ADDR_BITS-1:0];
                    b_ptr_reg <= cmd_payload_inputs_0[16 +: ADDR_BITS];
                    k_reg     <= cmd_k;
                    cidx_reg  <= cmd_payload_inputs_1[16 +: C_ADDR_BITS];
                    acc_reg   <= '0;
                    drain_reg <= 1'b0;
                    case (cmd_op)
                        OP_CLEAR: begin
                            offset_reg  <= '0;
                            payload_reg <= '0;
                        end
                        OP_WRITE: payload_reg <= '0;
                        OP_SET_OFFSET: begin
                            offset_reg  <= cmd_payload_inputs_0[8:0];
                            payload_reg <= 32'(offset_reg);
                        end
                        OP_COMPUTE, OP_READ_C, OP_DEBUG: ;
                        default: payload_reg <= '1;
                    endcase
                end
                MEMRD: begin
                    acc_reg <= c_rdata;
                    if (op_reg == OP_READ_C)
                        payload_reg <= 32'(c_rdata);
                    else if (op_reg == OP_DEBUG)
                        payload_reg <= f0_reg ? b_rdata : a_rdata;
                end
                EXEC: begin
                    a_ptr_reg <= a_ptr_reg + ADDR_BITS'(1);
                    b_ptr_reg <= b_ptr_reg + ADDR_BITS'(1);
                    k_reg     <= k_reg - 16'd1;
                    acc_reg   <= acc_sum;
                end
                DRAIN: begin
                    drain_reg <= 1'b1;
                    acc_reg   <= acc_sum;
                end
                default: ;
            endcase
        end
    end
endmodule
